// File: rtl/sap_sequencer_if.sv
// Bus bundle between the SAP T-state sequencer and its controller.
// It carries the enable/opcode inputs, the 12-bit control word and the status outputs.
interface sap_sequencer_if;
  logic       en;
  logic [3:0] ireg;
  logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
  logic [5:0] tstate;
  logic       halted;
  logic [7:0] instr_cnt;

  modport slave (
    input  en, ireg,
    output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo,
    output tstate, halted, instr_cnt
  );

  modport master (
    output en, ireg,
    input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo,
    input  tstate, halted, instr_cnt
  );
endinterface

// File: rtl/sap_sequencer.sv
// T-state sequencer for the 8-bit SAP processor. It steps through the T1..T6 ring,
// decodes the control word, handles HLT and counts completed instructions.
module sap_sequencer #(
  parameter logic [3:0] OP_LDA    = 4'h0,
  parameter logic [3:0] OP_ADD    = 4'h1,
  parameter logic [3:0] OP_SUB    = 4'h2,
  parameter logic [3:0] OP_OUT    = 4'hE,
  parameter logic [3:0] OP_HLT    = 4'hF,
  parameter bit         EARLY_END = 1'b0
) (
  input  logic            clk,
  input  logic            clr,
  sap_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_instrCnt;
  logic       w_isNop;
  logic       w_lastState;
  logic       w_enterT1;

  // The NOP early exit has to be decided on the T3 edge, so ireg is looked at one state early here.
  always_comb begin
    w_isNop = (bus.ireg != OP_LDA) && (bus.ireg != OP_ADD) && (bus.ireg != OP_SUB) &&
              (bus.ireg != OP_OUT) && (bus.ireg != OP_HLT);
    w_lastState = 1'b0;
    case (r_state)
      S_T3:    w_lastState = EARLY_END && w_isNop;
      S_T4:    w_lastState = EARLY_END && (bus.ireg == OP_OUT);
      S_T5:    w_lastState = EARLY_END && (bus.ireg == OP_LDA);
      S_T6:    w_lastState = 1'b1;
      default: w_lastState = 1'b0;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    if (bus.en && (r_state != S_HALT)) begin
      if ((r_state == S_T4) && (bus.ireg == OP_HLT)) begin
        w_nextState = S_HALT;
      end else if (w_lastState) begin
        w_nextState = S_T1;
      end else begin
        case (r_state)
          S_T1:    w_nextState = S_T2;
          S_T2:    w_nextState = S_T3;
          S_T3:    w_nextState = S_T4;
          S_T4:    w_nextState = S_T5;
          S_T5:    w_nextState = S_T6;
          default: w_nextState = S_T1;
        endcase
      end
    end
  end

  assign w_enterT1 = (w_nextState == S_T1) && (r_state != S_T1);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_T1;
      r_instrCnt <= 8'h00;
    end else begin
      r_state <= w_nextState;
      if (w_enterT1) begin
        r_instrCnt <= r_instrCnt + 8'h01;
      end
    end
  end

  // The word is gated by en and clr so a stalled or resetting cycle never loads a register.
  always_comb begin
    {bus.cp, bus.ep, bus.lm, bus.ce, bus.li, bus.ei,
     bus.la, bus.ea, bus.su, bus.eu, bus.lb, bus.lo} = 12'h000;
    if (!clr && bus.en) begin
      case (r_state)
        S_T1: begin bus.ep = 1'b1; bus.lm = 1'b1; end
        S_T2: bus.cp = 1'b1;
        S_T3: begin bus.ce = 1'b1; bus.li = 1'b1; end
        S_T4: begin
          if ((bus.ireg == OP_LDA) || (bus.ireg == OP_ADD) || (bus.ireg == OP_SUB)) begin
            bus.ei = 1'b1;
            bus.lm = 1'b1;
          end else if (bus.ireg == OP_OUT) begin
            bus.ea = 1'b1;
            bus.lo = 1'b1;
          end
        end
        S_T5: begin
          if (bus.ireg == OP_LDA) begin
            bus.ce = 1'b1;
            bus.la = 1'b1;
          end else if ((bus.ireg == OP_ADD) || (bus.ireg == OP_SUB)) begin
            bus.ce = 1'b1;
            bus.lb = 1'b1;
          end
        end
        S_T6: begin
          if ((bus.ireg == OP_ADD) || (bus.ireg == OP_SUB)) begin
            bus.eu = 1'b1;
            bus.la = 1'b1;
            bus.su = (bus.ireg == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_state)
      S_T1:    bus.tstate = 6'b000001;
      S_T2:    bus.tstate = 6'b000010;
      S_T3:    bus.tstate = 6'b000100;
      S_T4:    bus.tstate = 6'b001000;
      S_T5:    bus.tstate = 6'b010000;
      S_T6:    bus.tstate = 6'b100000;
      default: bus.tstate = 6'b000000;
    endcase
  end

  assign bus.halted    = (r_state == S_HALT);
  assign bus.instr_cnt = r_instrCnt;

endmodule

// File: tb/tb_sap_sequencer.sv
// Directed bench for sap_sequencer: one instance with EARLY_END=0 and one with EARLY_END=1,
// driven by the same clr/en/ireg stream and checked against hand-computed values.
module tb_sap_sequencer;

  logic       clk;
  logic       clr;
  logic       en;
  logic [3:0] ireg;
  logic       busCheckOn;
  int         totalCount;
  int         badCount;

  sap_sequencer_if bus0 ();
  sap_sequencer_if bus1 ();

  assign bus0.en   = en;
  assign bus0.ireg = ireg;
  assign bus1.en   = en;
  assign bus1.ireg = ireg;

  sap_sequencer #(.EARLY_END(1'b0)) dut0 (.clk(clk), .clr(clr), .bus(bus0.slave));
  sap_sequencer #(.EARLY_END(1'b1)) dut1 (.clk(clk), .clr(clr), .bus(bus1.slave));

  logic [11:0] cw0;
  logic [11:0] cw1;
  assign cw0 = {bus0.cp, bus0.ep, bus0.lm, bus0.ce, bus0.li, bus0.ei,
                bus0.la, bus0.ea, bus0.su, bus0.eu, bus0.lb, bus0.lo};
  assign cw1 = {bus1.cp, bus1.ep, bus1.lm, bus1.ce, bus1.li, bus1.ei,
                bus1.la, bus1.ea, bus1.su, bus1.eu, bus1.lb, bus1.lo};

  // Control word constants, bit order cp ep lm ce li ei la ea su eu lb lo.
  localparam logic [11:0] CW_T1      = 12'h600;
  localparam logic [11:0] CW_T2      = 12'h800;
  localparam logic [11:0] CW_T3      = 12'h180;
  localparam logic [11:0] CW_T4_MEM  = 12'h240;
  localparam logic [11:0] CW_T4_OUT  = 12'h011;
  localparam logic [11:0] CW_T5_LDA  = 12'h120;
  localparam logic [11:0] CW_T5_ALU  = 12'h102;
  localparam logic [11:0] CW_T6_ADD  = 12'h024;
  localparam logic [11:0] CW_T6_SUB  = 12'h02C;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic e, input logic [3:0] op);
    clr  = c;
    en   = e;
    ireg = op;
    #1;
  endtask

  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Only one of ep, ce, ei, ea, eu may drive the shared bus in any cycle.
  always @(negedge clk) begin
    if (busCheckOn) begin
      checkOutput("busDrv0", 32'(($countones({bus0.ep, bus0.ce, bus0.ei, bus0.ea, bus0.eu}) <= 1)), 32'd1);
      checkOutput("busDrv1", 32'(($countones({bus1.ep, bus1.ce, bus1.ei, bus1.ea, bus1.eu}) <= 1)), 32'd1);
    end
  end

  logic [5:0]  addTstate [6];
  logic [11:0] addWord   [6];

  initial begin
    totalCount = 0;
    badCount   = 0;
    busCheckOn = 1'b0;
    addTstate = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
    addWord   = '{CW_T1, CW_T2, CW_T3, CW_T4_MEM, CW_T5_ALU, CW_T6_ADD};

    // Reset
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 4'h1);
    stepEdges(1);
    applyStimulus(1'b0, 1'b1, 4'h1);
    busCheckOn = 1'b1;
    checkOutput("rstTstate0", 32'(bus0.tstate), 32'h01);
    checkOutput("rstHalted0", 32'(bus0.halted), 32'h0);
    checkOutput("rstCnt0", 32'(bus0.instr_cnt), 32'h0);
    checkOutput("rstWord0", 32'(cw0), 32'(CW_T1));
    checkOutput("rstTstate1", 32'(bus1.tstate), 32'h01);
    checkOutput("rstCnt1", 32'(bus1.instr_cnt), 32'h0);

    // ADD walks all six states in both modes
    for (int i = 1; i < 6; i++) begin
      stepEdges(1);
      checkOutput($sformatf("addT%0d_ts0", i + 1), 32'(bus0.tstate), 32'(addTstate[i]));
      checkOutput($sformatf("addT%0d_cw0", i + 1), 32'(cw0), 32'(addWord[i]));
      checkOutput($sformatf("addT%0d_cw1", i + 1), 32'(cw1), 32'(addWord[i]));
    end
    stepEdges(1);
    checkOutput("addEndTs0", 32'(bus0.tstate), 32'h01);
    checkOutput("addEndCnt0", 32'(bus0.instr_cnt), 32'd1);
    checkOutput("addEndCnt1", 32'(bus1.instr_cnt), 32'd1);

    // SUB asserts su in T6
    applyStimulus(1'b0, 1'b1, 4'h2);
    stepEdges(5);
    checkOutput("subT6cw0", 32'(cw0), 32'(CW_T6_SUB));
    checkOutput("subT6cw1", 32'(cw1), 32'(CW_T6_SUB));
    stepEdges(1);
    checkOutput("subEndCnt0", 32'(bus0.instr_cnt), 32'd2);
    checkOutput("subEndCnt1", 32'(bus1.instr_cnt), 32'd2);

    // HLT parks both sequencers until clr
    applyStimulus(1'b0, 1'b1, 4'hF);
    stepEdges(3);
    checkOutput("hltT4cw0", 32'(cw0), 32'h0);
    checkOutput("hltT4ts1", 32'(bus1.tstate), 32'h08);
    stepEdges(1);
    checkOutput("hltHalted0", 32'(bus0.halted), 32'h1);
    checkOutput("hltTs0", 32'(bus0.tstate), 32'h0);
    checkOutput("hltCw0", 32'(cw0), 32'h0);
    checkOutput("hltHalted1", 32'(bus1.halted), 32'h1);
    for (int i = 0; i < 20; i++) begin
      stepEdges(1);
      checkOutput("hltHoldTs0", 32'(bus0.tstate), 32'h0);
      checkOutput("hltHoldTs1", 32'(bus1.tstate), 32'h0);
    end
    checkOutput("hltHoldCnt0", 32'(bus0.instr_cnt), 32'd2);
    checkOutput("hltHoldCw1", 32'(cw1), 32'h0);
    applyStimulus(1'b1, 1'b1, 4'hE);
    stepEdges(1);
    applyStimulus(1'b0, 1'b1, 4'hE);
    checkOutput("hltClrTs0", 32'(bus0.tstate), 32'h01);
    checkOutput("hltClrHalted0", 32'(bus0.halted), 32'h0);
    checkOutput("hltClrCnt0", 32'(bus0.instr_cnt), 32'h0);

    // OUT ends after T4 only when EARLY_END=1
    stepEdges(3);
    checkOutput("outT4cw0", 32'(cw0), 32'(CW_T4_OUT));
    checkOutput("outT4cw1", 32'(cw1), 32'(CW_T4_OUT));
    stepEdges(1);
    checkOutput("outNextTs1", 32'(bus1.tstate), 32'h01);
    checkOutput("outNextCnt1", 32'(bus1.instr_cnt), 32'd1);
    checkOutput("outNextTs0", 32'(bus0.tstate), 32'h10);
    checkOutput("outT5cw0", 32'(cw0), 32'h0);
    applyStimulus(1'b1, 1'b1, 4'h0);
    stepEdges(1);
    applyStimulus(1'b0, 1'b1, 4'h0);

    // Stall in T3 of an LDA
    stepEdges(2);
    applyStimulus(1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      stepEdges(1);
      checkOutput("stallTs0", 32'(bus0.tstate), 32'h04);
      checkOutput("stallCw0", 32'(cw0), 32'h0);
    end
    applyStimulus(1'b0, 1'b1, 4'h0);
    checkOutput("stallRelCw0", 32'(cw0), 32'(CW_T3));
    checkOutput("stallRelCw1", 32'(cw1), 32'(CW_T3));
    stepEdges(2);
    checkOutput("ldaT5cw0", 32'(cw0), 32'(CW_T5_LDA));
    checkOutput("ldaT5cw1", 32'(cw1), 32'(CW_T5_LDA));

    // clr in the middle of LDA
    applyStimulus(1'b1, 1'b1, 4'h0);
    stepEdges(1);
    applyStimulus(1'b0, 1'b1, 4'h0);
    checkOutput("midClrTs0", 32'(bus0.tstate), 32'h01);
    checkOutput("midClrTs1", 32'(bus1.tstate), 32'h01);
    checkOutput("midClrCnt0", 32'(bus0.instr_cnt), 32'h0);

    // Full LDA: five cycles with EARLY_END=1
    stepEdges(5);
    checkOutput("ldaEndTs1", 32'(bus1.tstate), 32'h01);
    checkOutput("ldaEndCnt1", 32'(bus1.instr_cnt), 32'd1);
    checkOutput("ldaT6Ts0", 32'(bus0.tstate), 32'h20);
    checkOutput("ldaT6cw0", 32'(cw0), 32'h0);
    applyStimulus(1'b1, 1'b1, 4'h3);
    stepEdges(1);
    applyStimulus(1'b0, 1'b1, 4'h3);

    // NOP stream: 6 cycles each for dut0, 3 for dut1, counters wrap
    stepEdges(3);
    checkOutput("nopEndTs1", 32'(bus1.tstate), 32'h01);
    checkOutput("nopEndCnt1", 32'(bus1.instr_cnt), 32'd1);
    checkOutput("nopT4Ts0", 32'(bus0.tstate), 32'h08);
    checkOutput("nopT4cw0", 32'(cw0), 32'h0);
    stepEdges(1527);
    checkOutput("nopPreWrapCnt0", 32'(bus0.instr_cnt), 32'hFF);
    checkOutput("nopPreWrapCnt1", 32'(bus1.instr_cnt), 32'hFE);
    checkOutput("nopPreWrapTs0", 32'(bus0.tstate), 32'h01);
    stepEdges(6);
    checkOutput("nopWrapCnt0", 32'(bus0.instr_cnt), 32'h00);
    checkOutput("nopWrapCnt1", 32'(bus1.instr_cnt), 32'h00);
    checkOutput("nopWrapTs0", 32'(bus0.tstate), 32'h01);
    checkOutput("nopWrapTs1", 32'(bus1.tstate), 32'h01);

    busCheckOn = 1'b0;
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
